// File: rtl/flex_down_timer_if.sv
// Control/status bundle between a controlling FSM (master) and flex_down_timer (slave).
// prescale_val exists only when FLEX_DOWN_TIMER_PRESCALE_EN is defined.
interface flex_down_timer_if #(
    parameter int unsigned NUM_CNT_BITS = 4
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE_BITS = 4
`endif
);
    logic                     clear;
    logic                     start;
    logic [NUM_CNT_BITS-1:0]  load_val;
    logic                     count_enable;
    logic                     auto_reload;
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] prescale_val;
`endif
    logic [NUM_CNT_BITS-1:0]  count_out;
    logic                     busy;
    logic                     done;

`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
    modport master (
        output clear, start, load_val, count_enable, auto_reload, prescale_val,
        input  count_out, busy, done
    );
    modport slave (
        input  clear, start, load_val, count_enable, auto_reload, prescale_val,
        output count_out, busy, done
    );
`else
    modport master (
        output clear, start, load_val, count_enable, auto_reload,
        input  count_out, busy, done
    );
    modport slave (
        input  clear, start, load_val, count_enable, auto_reload,
        output count_out, busy, done
    );
`endif
endinterface

// File: rtl/flex_down_timer.sv
// Loadable down-counting timer with start/busy/done handshake and optional auto-reload.
// Optional prescaler enabled by defining FLEX_DOWN_TIMER_PRESCALE_EN.
module flex_down_timer #(
    parameter int unsigned NUM_CNT_BITS = 4
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE_BITS = 4
`endif
) (
    input  logic              clk,
    input  logic              n_rst,
    flex_down_timer_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    dec_tick;

`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] presc_q, presc_d;

    // Prescaler advances only on enabled RUN cycles; clear/start override below.
    always_comb begin
        presc_d  = presc_q;
        dec_tick = 1'b0;
        if (state_q == RUN && bus.count_enable) begin
            if (presc_q == bus.prescale_val) begin
                presc_d  = '0;
                dec_tick = 1'b1;
            end else begin
                presc_d = presc_q + PRESCALE_BITS'(1);
            end
        end
        if (bus.clear || bus.start) begin
            presc_d = '0;
        end
    end
`else
    always_comb begin
        dec_tick = (state_q == RUN) && bus.count_enable;
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            count_d = '0;
        end else if (bus.start) begin
            count_d = bus.load_val;
            if (bus.load_val != '0) begin
                state_d = RUN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (dec_tick) begin
            if (count_q > NUM_CNT_BITS'(1)) begin
                count_d = count_q - NUM_CNT_BITS'(1);
            end else begin
                // Expiry: reload keeps running unless the reload period is zero.
                done_d = 1'b1;
                if (bus.auto_reload && bus.load_val != '0) begin
                    count_d = bus.load_val;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
            presc_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
            presc_q <= presc_d;
`endif
        end
    end

    assign bus.count_out = count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_flex_down_timer.sv
// Self-checking bench for flex_down_timer: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the timer.
module tb_flex_down_timer;
    localparam int unsigned NB = 4;
    localparam int unsigned PB = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state (plain integers).
    int m_cnt = 0;
    bit m_run = 1'b0;
    bit m_done = 1'b0;
    int m_pre = 0;

    always #5 clk = ~clk;

`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
    flex_down_timer_if #(.NUM_CNT_BITS(NB), .PRESCALE_BITS(PB)) tif ();
    flex_down_timer #(.NUM_CNT_BITS(NB), .PRESCALE_BITS(PB)) dut (
        .clk(clk), .n_rst(n_rst), .bus(tif.slave));
`else
    flex_down_timer_if #(.NUM_CNT_BITS(NB)) tif ();
    flex_down_timer #(.NUM_CNT_BITS(NB)) dut (
        .clk(clk), .n_rst(n_rst), .bus(tif.slave));
`endif

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit clr, input bit st, input int lv, input bit ce,
                         input bit ar, input int pv);
        tif.clear        = clr;
        tif.start        = st;
        tif.load_val     = NB'(lv);
        tif.count_enable = ce;
        tif.auto_reload  = ar;
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
        tif.prescale_val = PB'(pv);
`else
        if (pv < 0) $display("prescale ignored");
`endif
    endtask

    task automatic model_reset();
        m_cnt = 0; m_run = 0; m_done = 0; m_pre = 0;
    endtask

    // One clock edge of the timer's documented behaviour.
    task automatic model_step();
        int  lv;
        bit  dec;
        lv     = int'(tif.load_val);
        m_done = 0;
        if (tif.clear) begin
            m_cnt = 0; m_run = 0; m_pre = 0;
        end else if (tif.start) begin
            m_cnt  = lv;
            m_pre  = 0;
            m_run  = (lv != 0);
            m_done = (lv == 0);
        end else if (m_run && tif.count_enable) begin
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
            dec = (m_pre == int'(tif.prescale_val));
            m_pre = dec ? 0 : (m_pre + 1) % (1 << PB);
`else
            dec = 1;
`endif
            if (dec) begin
                if (m_cnt > 1) m_cnt = m_cnt - 1;
                else begin
                    m_done = 1;
                    if (tif.auto_reload && lv != 0) m_cnt = lv;
                    else begin m_cnt = 0; m_run = 0; end
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, int'(tif.count_out), m_cnt);
        check({tag, "_busy"}, int'(tif.busy), int'(m_run));
        check({tag, "_done"}, int'(tif.done), int'(m_done));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int n;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        compare_all("reset");
        n_rst = 1'b1;
        @(posedge clk); #1;

        // 1: one-shot period of 3
        drive(0, 1, 3, 1, 0, 0);
        step("t1_load");
        check("t1_load_val", int'(tif.count_out), 3);
        drive(0, 0, 3, 1, 0, 0);
        step("t1_a");
        step("t1_b");
        step("t1_exp");
        check("t1_exp_done", int'(tif.done), 1);
        check("t1_exp_busy", int'(tif.busy), 0);
        step("t1_after");
        check("t1_after_done", int'(tif.done), 0);

        // 2: auto-reload period of 4
        drive(0, 1, 4, 1, 1, 0);
        step("t2_load");
        drive(0, 0, 4, 1, 1, 0);
        for (int i = 0; i < 9; i++) step("t2_run");

        // 3: enable gating then zero-length start
        drive(0, 1, 5, 0, 0, 0);
        step("t3_load");
        drive(0, 0, 5, 1, 0, 0); step("t3_e1");
        drive(0, 0, 5, 0, 0, 0); step("t3_e0a"); step("t3_e0b");
        drive(0, 0, 5, 1, 0, 0); step("t3_e1b");
        check("t3_count", int'(tif.count_out), 3);
        drive(0, 1, 0, 1, 0, 0);
        step("t3_zero");
        check("t3_zero_done", int'(tif.done), 1);

        // 4: restart mid-run, then clear beats start
        drive(0, 1, 4, 1, 0, 0); step("t4_load");
        drive(0, 0, 4, 1, 0, 0); step("t4_a"); step("t4_b");
        drive(0, 1, 7, 1, 0, 0); step("t4_restart");
        check("t4_restart_count", int'(tif.count_out), 7);
        drive(1, 1, 9, 1, 0, 0); step("t4_clear");
        check("t4_clear_count", int'(tif.count_out), 0);

        // 5: asynchronous reset mid-run
        drive(0, 1, 5, 0, 0, 0); step("t5_load");
        #2 n_rst = 1'b0;
        model_reset();
        #1 compare_all("t5_async");
        #3 n_rst = 1'b1;
        drive(0, 0, 5, 1, 1, 0);
        step("t5_idle_a"); step("t5_idle_b");

        // 6: prescaled period
        drive(0, 1, 2, 1, 0, 2); step("t6_load");
        drive(0, 0, 2, 1, 0, 2);
        n = 0;
        while (tif.done !== 1'b1 && n < 40) begin
            step("t6_run");
            n++;
        end
`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
        check("t6_enabled_cycles", n, 6);
`else
        check("t6_enabled_cycles", n, 2);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 25) == 0, ($urandom % 7) == 0,
                  (($urandom % 5) == 0) ? 0 : int'($urandom_range(1, 15)),
                  ($urandom % 4) != 0, $urandom % 2, int'($urandom_range(0, 3)));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
